// File: rtl/button_debouncer_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer_if
//  Description : Button bundle between the raw push-button pins and the
//                debouncer. The master side drives the raw inputs; the slave
//                side (the debouncer) returns the clean level and the
//                press/release pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface button_debouncer_if #(
    parameter int N = 2
);
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    // Producer of raw button activity (board pins, testbench)
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    // The debouncer itself
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Multi-channel push-button conditioner. Each raw asynchronous
//                input is brought into the clk domain through a two-flop
//                synchronizer, then debounced by a four-state machine that
//                only accepts a new level after DEBOUNCE_CYCLES consecutive
//                identical synchronized samples. Outputs are a registered
//                clean level plus single-cycle press and release pulses.
//  Options     : define BUTTON_DEBOUNCER_AUTOREPEAT_EN to add hold-to-repeat
//                pulses on btn_press (first after REPEAT_DELAY cycles, then
//                every REPEAT_PERIOD cycles while the button stays down).
//                Without it the REPEAT_* / RPT_W parameters are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int N               = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int RPT_W           = 25
) (
    input  wire logic         clk,
    input  wire logic         reset,
    button_debouncer_if.slave btn
);

    // ------------------------------------------------------------------------
    // Per-channel debounce state. Explicit 2-bit encoding so the state
    // register width is fixed regardless of tool choices.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHK_HIGH    = 2'd1,
        STABLE_HIGH = 2'd2,
        CHK_LOW     = 2'd3
    } state_t;

    // Terminal count: the counter stops here, so it never wraps.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    // Repeat counter terminal values. The counter restarts from zero after
    // every pulse, so the first interval uses the delay and later ones the
    // period.
    localparam logic [RPT_W-1:0] C_RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] C_RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] C_RPT_ONE         = RPT_W'(1);
`else
    // Repeat configuration is accepted for drop-in compatibility but has no
    // hardware behind it; fold it into a deliberately unused wire.
    logic w_unused_rpt_cfg;
    assign w_unused_rpt_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD), 32'(RPT_W)};
`endif

    // ------------------------------------------------------------------------
    // One fully independent conditioner per button.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_ch

        logic             r_sync1;
        logic             r_sync2;
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;
        logic             r_press;
        logic             r_release;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
        logic [RPT_W-1:0] r_rpt;
        logic             r_rpt_first;
`endif

        // Two-flop synchronizer: raw pin is asynchronous to clk
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= btn.btn_raw[gi];
                r_sync2 <= r_sync1;
            end
        end

        // Debounce FSM with registered level/pulse outputs (and repeat timer)
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state     <= STABLE_LOW;
                r_cnt       <= '0;
                r_level     <= 1'b0;
                r_press     <= 1'b0;
                r_release   <= 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
                r_rpt       <= '0;
                r_rpt_first <= 1'b0;
`endif
            end else begin
                // Pulses are single-cycle unless re-asserted below
                r_press   <= 1'b0;
                r_release <= 1'b0;

                case (r_state)
                    STABLE_LOW: begin
                        if (r_sync2) begin
                            r_state <= CHK_HIGH;
                            r_cnt   <= '0;
                        end
                    end

                    CHK_HIGH: begin
                        if (!r_sync2) begin
                            // Bounce: drop back without touching outputs
                            r_state <= STABLE_LOW;
                        end else if (r_cnt == C_CNT_LAST) begin
                            r_state     <= STABLE_HIGH;
                            r_level     <= 1'b1;
                            r_press     <= 1'b1;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
                            r_rpt       <= '0;
                            r_rpt_first <= 1'b1;
`endif
                        end else begin
                            r_cnt <= r_cnt + C_CNT_ONE;
                        end
                    end

                    STABLE_HIGH: begin
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
                        // Hold timer runs for every cycle spent here
                        if (r_rpt_first && (r_rpt == C_RPT_DELAY_LAST)) begin
                            r_press     <= 1'b1;
                            r_rpt       <= '0;
                            r_rpt_first <= 1'b0;
                        end else if (!r_rpt_first && (r_rpt == C_RPT_PERIOD_LAST)) begin
                            r_press <= 1'b1;
                            r_rpt   <= '0;
                        end else begin
                            r_rpt <= r_rpt + C_RPT_ONE;
                        end
`endif
                        if (!r_sync2) begin
                            r_state <= CHK_LOW;
                            r_cnt   <= '0;
                        end
                    end

                    CHK_LOW: begin
                        // Repeat timer is frozen here; a rejected release
                        // resumes it from where it stopped.
                        if (r_sync2) begin
                            r_state <= STABLE_HIGH;
                        end else if (r_cnt == C_CNT_LAST) begin
                            r_state   <= STABLE_LOW;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_ONE;
                        end
                    end

                    default: begin
                        r_state <= STABLE_LOW;
                    end
                endcase
            end
        end

        assign btn.btn_level[gi]   = r_level;
        assign btn.btn_press[gi]   = r_press;
        assign btn.btn_release[gi] = r_release;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debouncer
//  Description : Self-checking bench for button_debouncer (N=2,
//                DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
//                Define BUTTON_DEBOUNCER_AUTOREPEAT_EN for both bench and RTL
//                to exercise the repeat option.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int N   = 2;
    localparam int DEB = 4;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    button_debouncer_if #(.N(N)) bif ();

    button_debouncer #(
        .N               (N),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .RPT_W           (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record: raw value held for n cycles, expected outputs after each edge
    typedef struct {
        logic [1:0] raw;
        int         n;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [1:0] el,
                         input logic [1:0] ep, input logic [1:0] er);
        checks++;
        if ({bif.btn_level, bif.btn_press, bif.btn_release} !== {el, ep, er}) begin
            errors++;
            $display("FAIL %s: got level=%b press=%b release=%b, expected level=%b press=%b release=%b",
                     name, bif.btn_level, bif.btn_press, bif.btn_release, el, ep, er);
        end
    endtask

    initial begin
        int idx;
        logic [1:0] ep;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bif.btn_raw = 2'b00;

        // Clean press ch0, release, bounce, then simultaneous events
        tbl[0]  = '{2'b01, 6, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{2'b01, 1, 2'b01, 2'b01, 2'b00};
        tbl[2]  = '{2'b01, 2, 2'b01, 2'b00, 2'b00};
        tbl[3]  = '{2'b00, 6, 2'b01, 2'b00, 2'b00};
        tbl[4]  = '{2'b00, 1, 2'b00, 2'b00, 2'b01};
        tbl[5]  = '{2'b00, 2, 2'b00, 2'b00, 2'b00};
        tbl[6]  = '{2'b01, 3, 2'b00, 2'b00, 2'b00};
        tbl[7]  = '{2'b00, 2, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{2'b01, 6, 2'b00, 2'b00, 2'b00};
        tbl[9]  = '{2'b01, 1, 2'b01, 2'b01, 2'b00};
        tbl[10] = '{2'b01, 1, 2'b01, 2'b00, 2'b00};
        tbl[11] = '{2'b10, 6, 2'b01, 2'b00, 2'b00};
        tbl[12] = '{2'b10, 1, 2'b10, 2'b10, 2'b01};
        tbl[13] = '{2'b10, 2, 2'b10, 2'b00, 2'b00};
        tbl[14] = '{2'b01, 6, 2'b10, 2'b00, 2'b00};
        tbl[15] = '{2'b01, 1, 2'b01, 2'b01, 2'b10};
        tbl[16] = '{2'b01, 2, 2'b01, 2'b00, 2'b00};

        repeat (3) @(posedge clk);
        #1 check("reset_values", 2'b00, 2'b00, 2'b00);
        @(negedge clk) reset = 1'b0;

        // Table-driven section
        idx = 0;
        for (int r = 0; r < 17; r++) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                bif.btn_raw = tbl[r].raw;
                @(posedge clk);
                #1 check($sformatf("vec_%0d", idx), tbl[r].lvl, tbl[r].prs, tbl[r].rel);
                idx++;
            end
        end

        // Reset mid-check: ch1 stable high, ch0 in CHK_HIGH
        bif.btn_raw = 2'b00;
        repeat (9) @(posedge clk);
        #1 check("rst_prep_low", 2'b00, 2'b00, 2'b00);
        bif.btn_raw = 2'b10;
        repeat (9) @(posedge clk);
        #1 check("rst_prep_ch1", 2'b10, 2'b00, 2'b00);
        bif.btn_raw = 2'b11;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1 check("reset_async", 2'b00, 2'b00, 2'b00);
        repeat (3) @(posedge clk);
        #1 check("reset_hold", 2'b00, 2'b00, 2'b00);
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1 check($sformatf("post_reset_%0d", k),
                     (k >= 6) ? 2'b11 : 2'b00,
                     (k == 6) ? 2'b11 : 2'b00, 2'b00);
        end

        // Long hold on ch0 (repeat pulses only with the option), then release
        bif.btn_raw = 2'b00;
        repeat (9) @(posedge clk);
        #1 check("ar_prep", 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 47; k++) begin
            int t;
            t = k - 6;
            bif.btn_raw = (k < 36) ? 2'b01 : 2'b00;
            @(posedge clk);
            ep = 2'b00;
            if (t == 0)
                ep = 2'b01;
            else if (AR && t >= 10 && t <= 31 && ((t - 10) % 3) == 0)
                ep = 2'b01;
            #1 check($sformatf("hold_%0d", k),
                     (k >= 6 && k < 42) ? 2'b01 : 2'b00,
                     ep,
                     (k == 42) ? 2'b01 : 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_debouncer.md
# button_debouncer

Multi-channel push-button conditioner that sits directly upstream of the up/down counter and other button-driven blocks. Each raw, asynchronous, bouncing button input is synchronized, debounced by a per-channel state machine, and presented as a clean level plus single-cycle press/release pulses. The clean level drives the counter's enable input, and the pulses serve blocks that need one event per press.

## Interface
- `N`, 2: number of independent button channels, ≥1.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronized samples required to accept a change, ≥1. The default is 10 ms at 50 MHz.
- `CNT_W`, 20: debounce counter width; 2^CNT_W > DEBOUNCE_CYCLES.
- `REPEAT_DELAY`, 25000000: hold time, in cycles, from the initial press pulse to the first auto-repeat pulse, ≥1.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent auto-repeat pulses, ≥1.
- `RPT_W`, 25: repeat counter width; 2^RPT_W > max(REPEAT_DELAY, REPEAT_PERIOD).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `btn_raw` in N: raw button inputs, asynchronous to clk, active-high.
- `btn_level` out N: debounced, registered button level.
- `btn_press` out N: one-cycle pulse on each accepted press, plus auto-repeat pulses when that feature is configured.
- `btn_release` out N: one-cycle pulse on each accepted release.

## Operation
- **Synchronizer:** each channel passes through a 2-FF synchronizer (`sync1`, then `sync2`). Both flops reset to 0.
- **Per-channel FSM states:** STABLE_LOW, CHK_HIGH, STABLE_HIGH, CHK_LOW. The FSM resets to STABLE_LOW with counter = 0.
- **STABLE_LOW:**
  - `sync2`=1: go to CHK_HIGH and clear the counter.
  - Otherwise: hold.
- **CHK_HIGH:**
  - `sync2`=0: bounce rejected; return to STABLE_LOW. No output change.
  - `sync2`=1 and counter == DEBOUNCE_CYCLES-1: go to STABLE_HIGH, set `btn_level`=1, and pulse `btn_press` for one cycle.
  - Otherwise: increment the counter.
- **STABLE_HIGH and CHK_LOW:** mirror of the above with polarity inverted. Acceptance clears `btn_level` and pulses `btn_release`.
- **Counter range:** the debounce counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- **Independence:** channels are fully independent. Simultaneous events on different channels are each handled on their own.
- **Output registers:** all outputs are registered. The pulse outputs default to 0 every cycle unless asserted by that cycle's transition.
- **Reset mid-operation:** any check in progress is aborted, and all outputs go to 0 asynchronously.
- **Raw held high through reset:** treated as a new press after reset deasserts, with full debounce latency applied.

## Timing
- **Edge numbering:** edge 0 is the first clk edge at which `sync1` samples a new stable raw value.
  - Edge 1: `sync2` updates.
  - Edge 2: FSM enters the CHK state.
  - Edge 2+DEBOUNCE_CYCLES: `btn_level` toggles, and `btn_press` or `btn_release` is high for exactly the following cycle.
- **Latency:** DEBOUNCE_CYCLES+2 edges from first sample to the output change.
- **Glitch rejection:** any synchronized glitch shorter than DEBOUNCE_CYCLES samples produces no output change.
- **Pulse/level alignment:** `btn_press` is coincident with the 0→1 cycle of `btn_level`, and `btn_release` with the 1→0 cycle. The two are never high together on one channel.
- **Reset values:** `btn_level`=0, `btn_press`=0, `btn_release`=0.

## Configuration
- **Macro:** `BUTTON_DEBOUNCER_AUTOREPEAT_EN`.
- **With the macro defined:**
  - Each channel has a RPT_W-bit repeat counter, cleared on entry to STABLE_HIGH from CHK_HIGH.
  - The counter runs while in STABLE_HIGH and freezes in CHK_LOW. If the release is rejected, counting resumes without clearing.
  - The first repeat pulse comes REPEAT_DELAY cycles after the initial `btn_press` pulse; later pulses come every REPEAT_PERIOD cycles.
  - Repeat pulses appear on `btn_press` only. `btn_level` stays high throughout.
  - Accepted release stops repeats immediately.
- **Without the macro:**
  - No repeat logic is present.
  - `btn_press` pulses exactly once per accepted press.
  - The REPEAT_* and RPT_W parameters are accepted but unused.

## Test plan
Bench parameters: N=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- **Clean press:** `btn_raw[0]` 0→1 and held → `btn_level[0]`=1 and a single `btn_press[0]` pulse, both 6 edges after the first sample. `btn_release` stays 0 and channel 1 is unaffected.
- **Bounce rejection:** `btn_raw[0]` high for 3 cycles, low for 2, then high and held → no output during the bounce; `btn_level[0]` rises 6 edges after the final rising sample.
- **Release:** after an accepted press, hold the raw input low → `btn_level[0]` falls and `btn_release[0]` pulses once, 6 edges after the first low sample.
- **Simultaneous events:** channel 0 pressed and channel 1 released on the same cycle → `btn_press[0]` and `btn_release[1]` pulse on the same cycle.
- **Reset mid-check:** reset asserted during CHK_HIGH with raw still high → outputs 0 immediately; after deassert, `btn_level` rises 6 edges after the first post-reset sample.
- **Auto-repeat (macro defined):** hold the press for 30 cycles → `btn_press` pulses at relative cycles 0, 10, 13, 16, 19, …, 28. Without the macro: a single pulse only.
